amm_cmd_driver: RTL and testbench
=================================

Name: amm_cmd_driver

Overview:
- Downstream of the control block. Accepts one transaction at a time over a valid/ready handshake: operation type, word address, word burst count, start/end byte offsets.
- Turns each transaction into an Avalon-MM master burst: a write burst with generated data and byteenables, or a single read command.
- Read data checking is handled in a separate block and is out of scope here.

Parameters:
- AMM_DATA_W, 128, Avalon data width; must be a multiple of 32.
- AMM_ADDR_W, 12, Avalon byte address width.
- AMM_BURST_W, 11, Avalon burstcount width.
- BYTE_PER_WORD, AMM_DATA_W/8, bytes per data word.
- BYTE_ADDR_W, $clog2(BYTE_PER_WORD), byte-offset width.
- ADDR_W, AMM_ADDR_W-BYTE_ADDR_W, word address width.

Ports:
- clk_i  in  1  single clock.
- rst_i  in  1  asynchronous, active-low reset.
- start_test_i  in  1  test start pulse; reseeds the data generator.
- operation_valid_i  in  1  transaction valid.
- operation_type_i  in  1  0=write, 1=read.
- word_address_i  in  ADDR_W  start word address.
- word_burst_count_i  in  AMM_BURST_W  number of words.
- start_offset_i  in  BYTE_ADDR_W  first valid byte in the first word.
- end_offset_i  in  BYTE_ADDR_W  last valid byte in the last word.
- data_pattern_i  in  8  write byte pattern.
- cmd_accept_ready_o  out  1  ready for a transaction.
- busy_o  out  1  burst in progress.
- amm_address_o  out  AMM_ADDR_W  Avalon address.
- amm_read_o  out  1  Avalon read.
- amm_write_o  out  1  Avalon write.
- amm_writedata_o  out  AMM_DATA_W  write data.
- amm_byteenable_o  out  BYTE_PER_WORD  byte enables.
- amm_burstcount_o  out  AMM_BURST_W  burst length.
- amm_waitrequest_i  in  1  slave stall.

Behaviour:
- Reset (rst_i low, async): state IDLE; cmd_accept_ready_o=1; all other outputs 0; beat counter 0.
- Only Avalon signals are registered. cmd_accept_ready_o is decoded from state (1 only in IDLE); busy_o = !cmd_accept_ready_o.
- Handshake: a transaction is accepted when operation_valid_i && cmd_accept_ready_o. At acceptance, all transaction fields are latched and the input fields are don't-care afterwards.
- States:
  - IDLE: on accept with type=0 go to WR_BURST; with type=1 go to RD_CMD.
  - WR_BURST: amm_write_o=1 from the cycle after accept. A beat completes when amm_write_o && !amm_waitrequest_i. Completion of the last beat returns to IDLE, with amm_write_o=0 in the following cycle.
  - RD_CMD: amm_read_o=1 from the cycle after accept. When !amm_waitrequest_i, return to IDLE.
- Latency: accept at cycle N drives the Avalon command at N+1. Minimum gap is one IDLE cycle between bursts.
- Address and burst count:
  - amm_address_o = {latched word address, BYTE_ADDR_W zeros}.
  - amm_address_o and amm_burstcount_o are constant for the whole burst.
  - A word_burst_count_i of 0 is treated as 1.
- Beat counter: counts completed beats; last beat when count == burstcount-1. While waitrequest is high, writedata and byteenable are held unchanged.
- Byteenable:
  - first_mask: bits [BYTE_PER_WORD-1 : start_offset] set.
  - last_mask: bits [end_offset : 0] set.
  - Single-word burst: first_mask & last_mask.
  - Multi-word burst: first beat first_mask, last beat last_mask, middle beats all ones.
  - Reads: byteenable all ones.
- Write data: data_pattern_i replicated across every byte; the pattern is latched at accept.
- Simultaneous events:
  - operation_valid_i while busy is ignored; the source holds it.
  - start_test_i during a burst does not abort the burst.
  - Reset mid-burst aborts immediately to the reset values.

Optional Feature:
- Macro: AMM_CMD_DRIVER_RND_DATA_EN.
- Defined:
  - Write data comes from a 32-bit Galois LFSR (x^32+x^22+x^2+x+1) replicated across AMM_DATA_W/32 lanes.
  - The LFSR is seeded to 32'hFFFF_FFFF on start_test_i and advances once per completed write beat only.
  - data_pattern_i is ignored.
- Undefined: pattern replication as described; no LFSR logic is built.

Test Plan:
- Write, address 0x010, burst 1, start 3, end 5, pattern 0xA5, waitrequest 0 -> one beat; byteenable 0x0038; writedata all 0xA5; address 0x100; ready returns after 2 cycles.
- Write, burst 4, start 2, end 1, waitrequest high on the 2nd beat for 3 cycles -> byteenable 0xFFFC, 0xFFFF, 0xFFFF, 0x0003; data and byteenable held during the stall; burstcount stays 4.
- Read, burst 8, waitrequest high for 3 cycles -> amm_read_o high for exactly 4 cycles; burstcount 8; byteenable 0xFFFF; then IDLE.
- Burst count 0, write -> exactly one beat with burstcount 1.
- rst_i low during beat 2 of a 4-beat write -> amm_write_o drops asynchronously; ready=1 after release; the next transaction starts cleanly.
- With AMM_CMD_DRIVER_RND_DATA_EN: start_test_i then a 3-beat write with stalls -> lanes equal 0xFFFFFFFF, then the next two LFSR values; no advance during stalls.

Source files
------------

// File: rtl/amm_cmd_driver.sv
// ============================================================================
// Module   : amm_cmd_driver
// Brief    : Turns one accepted transaction into an Avalon-MM master burst:
//            a write burst with generated data/byteenables, or a single read
//            command. Optional LFSR write data when AMM_CMD_DRIVER_RND_DATA_EN
//            is defined; otherwise write data is the replicated byte pattern.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module amm_cmd_driver #(
    parameter int AMM_DATA_W    = 128,
    parameter int AMM_ADDR_W    = 12,
    parameter int AMM_BURST_W   = 11,
    parameter int BYTE_PER_WORD = AMM_DATA_W / 8,
    parameter int BYTE_ADDR_W   = $clog2(BYTE_PER_WORD),
    parameter int ADDR_W        = AMM_ADDR_W - BYTE_ADDR_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_test_i,
    input  logic                     operation_valid_i,
    input  logic                     operation_type_i,
    input  logic [ADDR_W-1:0]        word_address_i,
    input  logic [AMM_BURST_W-1:0]   word_burst_count_i,
    input  logic [BYTE_ADDR_W-1:0]   start_offset_i,
    input  logic [BYTE_ADDR_W-1:0]   end_offset_i,
    input  logic [7:0]               data_pattern_i,
    output logic                     cmd_accept_ready_o,
    output logic                     busy_o,
    output logic [AMM_ADDR_W-1:0]    amm_address_o,
    output logic                     amm_read_o,
    output logic                     amm_write_o,
    output logic [AMM_DATA_W-1:0]    amm_writedata_o,
    output logic [BYTE_PER_WORD-1:0] amm_byteenable_o,
    output logic [AMM_BURST_W-1:0]   amm_burstcount_o,
    input  logic                     amm_waitrequest_i
);

    localparam int                       c_lanes     = AMM_DATA_W / 32;
    localparam logic [AMM_BURST_W-1:0]   c_burst_one = AMM_BURST_W'(1);
    localparam logic [BYTE_ADDR_W-1:0]   c_max_off   = BYTE_ADDR_W'(BYTE_PER_WORD - 1);
    localparam logic [BYTE_PER_WORD-1:0] c_all_bytes = '1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WR_BURST = 2'd1,
        S_RD_CMD   = 2'd2
    } state_t;

    state_t                   r_state;
    logic [AMM_ADDR_W-1:0]    r_address;
    logic [AMM_BURST_W-1:0]   r_burstcount;
    logic [AMM_BURST_W-1:0]   r_beat_cnt;
    logic                     r_read;
    logic                     r_write;
    logic [AMM_DATA_W-1:0]    r_writedata;
    logic [BYTE_PER_WORD-1:0] r_byteenable;
    logic [BYTE_ADDR_W-1:0]   r_end_off;

    logic                     w_accept;
    logic                     w_beat_done;
    logic                     w_last_beat;
    logic                     w_next_is_last;
    logic [AMM_BURST_W-1:0]   w_burst_in;
    logic [AMM_DATA_W-1:0]    w_gen_data;
    logic [AMM_DATA_W-1:0]    w_beat_data;

    // Bytes from the start offset up to the top of the word
    function automatic logic [BYTE_PER_WORD-1:0] f_first_mask(input logic [BYTE_ADDR_W-1:0] off);
        return c_all_bytes << off;
    endfunction

    // Bytes from the bottom of the word up to the end offset
    function automatic logic [BYTE_PER_WORD-1:0] f_last_mask(input logic [BYTE_ADDR_W-1:0] off);
        return c_all_bytes >> (c_max_off - off);
    endfunction

    assign cmd_accept_ready_o = (r_state == S_IDLE);
    assign busy_o             = !cmd_accept_ready_o;
    assign w_accept           = operation_valid_i && cmd_accept_ready_o;
    // A zero burst count still moves one word
    assign w_burst_in         = (word_burst_count_i == '0) ? c_burst_one : word_burst_count_i;
    assign w_beat_done        = r_write && !amm_waitrequest_i;
    assign w_last_beat        = (r_beat_cnt == (r_burstcount - c_burst_one));
    assign w_next_is_last     = ((r_beat_cnt + c_burst_one) == (r_burstcount - c_burst_one));

`ifdef AMM_CMD_DRIVER_RND_DATA_EN
    localparam logic [31:0] c_lfsr_seed = 32'hFFFF_FFFF;
    localparam logic [31:0] c_lfsr_taps = 32'h8020_0003;   // x^32+x^22+x^2+x+1

    logic [31:0] r_lfsr;
    logic [31:0] w_lfsr_step;
    logic [31:0] w_lfsr_upd;
    logic        w_unused_pattern;

    assign w_unused_pattern = |data_pattern_i;
    assign w_lfsr_step      = {1'b0, r_lfsr[31:1]} ^ ({32{r_lfsr[0]}} & c_lfsr_taps);
    // Reseed wins; otherwise advance only when a write beat is taken
    assign w_lfsr_upd       = start_test_i ? c_lfsr_seed :
                              (w_beat_done ? w_lfsr_step : r_lfsr);
    assign w_gen_data       = {c_lanes{w_lfsr_upd}};
    assign w_beat_data      = w_gen_data;

    // LFSR state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_lfsr <= c_lfsr_seed;
        end else begin
            r_lfsr <= w_lfsr_upd;
        end
    end
`else
    logic w_unused_start;

    assign w_unused_start = start_test_i;
    assign w_gen_data     = {BYTE_PER_WORD{data_pattern_i}};
    // Pattern data is constant for the whole burst
    assign w_beat_data    = r_writedata;
`endif

    // Command FSM with registered Avalon outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= S_IDLE;
            r_address    <= '0;
            r_burstcount <= '0;
            r_beat_cnt   <= '0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_writedata  <= '0;
            r_byteenable <= '0;
            r_end_off    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_address    <= {word_address_i, {BYTE_ADDR_W{1'b0}}};
                        r_burstcount <= w_burst_in;
                        r_beat_cnt   <= '0;
                        r_end_off    <= end_offset_i;
                        if (operation_type_i) begin
                            r_read       <= 1'b1;
                            r_byteenable <= c_all_bytes;
                            r_state      <= S_RD_CMD;
                        end else begin
                            r_write      <= 1'b1;
                            r_writedata  <= w_gen_data;
                            r_byteenable <= (w_burst_in == c_burst_one) ?
                                            (f_first_mask(start_offset_i) & f_last_mask(end_offset_i)) :
                                            f_first_mask(start_offset_i);
                            r_state      <= S_WR_BURST;
                        end
                    end
                end
                S_WR_BURST: begin
                    if (w_beat_done) begin
                        if (w_last_beat) begin
                            r_write <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_beat_cnt   <= r_beat_cnt + c_burst_one;
                            r_writedata  <= w_beat_data;
                            r_byteenable <= w_next_is_last ? f_last_mask(r_end_off) : c_all_bytes;
                        end
                    end
                end
                S_RD_CMD: begin
                    if (!amm_waitrequest_i) begin
                        r_read  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign amm_address_o    = r_address;
    assign amm_burstcount_o = r_burstcount;
    assign amm_read_o       = r_read;
    assign amm_write_o      = r_write;
    assign amm_writedata_o  = r_writedata;
    assign amm_byteenable_o = r_byteenable;

endmodule

`default_nettype wire

// File: tb/tb_amm_cmd_driver.sv
// ============================================================================
// Module   : tb_amm_cmd_driver
// Brief    : Scoreboard bench for amm_cmd_driver. Expected beats are queued
//            when a transaction is accepted and compared as the DUT drives
//            them. Define AMM_CMD_DRIVER_RND_DATA_EN for the LFSR build.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_amm_cmd_driver;

    localparam int DW  = 128;
    localparam int AW  = 12;
    localparam int BW  = 11;
    localparam int BPW = 16;
    localparam int BAW = 4;
    localparam int WAW = 8;

    typedef struct packed {
        logic           rd;
        logic [AW-1:0]  addr;
        logic [BW-1:0]  bc;
        logic [BPW-1:0] be;
        logic [DW-1:0]  data;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst_i = 1'b0;
    logic           start_test_i = 1'b0;
    logic           operation_valid_i = 1'b0;
    logic           operation_type_i = 1'b0;
    logic [WAW-1:0] word_address_i = '0;
    logic [BW-1:0]  word_burst_count_i = '0;
    logic [BAW-1:0] start_offset_i = '0;
    logic [BAW-1:0] end_offset_i = '0;
    logic [7:0]     data_pattern_i = '0;
    logic           cmd_accept_ready_o;
    logic           busy_o;
    logic [AW-1:0]  amm_address_o;
    logic           amm_read_o;
    logic           amm_write_o;
    logic [DW-1:0]  amm_writedata_o;
    logic [BPW-1:0] amm_byteenable_o;
    logic [BW-1:0]  amm_burstcount_o;
    logic           amm_waitrequest_i = 1'b0;

    beat_t       sb[$];
    int          total = 0;
    int          bad = 0;
    int          beats = 0;
    int          rd_cycles = 0;
    logic [31:0] m_lfsr = 32'hFFFF_FFFF;

    amm_cmd_driver dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .start_test_i       (start_test_i),
        .operation_valid_i  (operation_valid_i),
        .operation_type_i   (operation_type_i),
        .word_address_i     (word_address_i),
        .word_burst_count_i (word_burst_count_i),
        .start_offset_i     (start_offset_i),
        .end_offset_i       (end_offset_i),
        .data_pattern_i     (data_pattern_i),
        .cmd_accept_ready_o (cmd_accept_ready_o),
        .busy_o             (busy_o),
        .amm_address_o      (amm_address_o),
        .amm_read_o         (amm_read_o),
        .amm_write_o        (amm_write_o),
        .amm_writedata_o    (amm_writedata_o),
        .amm_byteenable_o   (amm_byteenable_o),
        .amm_burstcount_o   (amm_burstcount_o),
        .amm_waitrequest_i  (amm_waitrequest_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    // Reference model: expand one transaction into its expected beats
    task automatic push_txn(input logic typ, input logic [WAW-1:0] w, input logic [BW-1:0] bc,
                            input logic [BAW-1:0] so, input logic [BAW-1:0] eo, input logic [7:0] pat);
        int             n;
        beat_t          b;
        logic [BPW-1:0] fm;
        logic [BPW-1:0] lm;
        n  = (bc == '0) ? 1 : int'(bc);
        fm = '0;
        lm = '0;
        for (int k = 0; k < BPW; k++) begin
            if (k >= int'(so)) fm[k] = 1'b1;
            if (k <= int'(eo)) lm[k] = 1'b1;
        end
        b.rd   = typ;
        b.addr = {w, 4'h0};
        b.bc   = BW'(n);
        b.data = '0;
        if (typ) begin
            b.be = '1;
            sb.push_back(b);
        end else begin
            for (int i = 0; i < n; i++) begin
                if (n == 1)          b.be = fm & lm;
                else if (i == 0)     b.be = fm;
                else if (i == n - 1) b.be = lm;
                else                 b.be = '1;
`ifdef AMM_CMD_DRIVER_RND_DATA_EN
                b.data = {4{m_lfsr}};
                m_lfsr = lfsr_next(m_lfsr);
`else
                b.data = {16{pat}};
`endif
                sb.push_back(b);
            end
        end
    endtask

    // Compare the Avalon command against the head of the scoreboard
    task automatic monitor();
        beat_t e;
        if (amm_write_o || amm_read_o) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_cmd: got rd=%0b wr=%0b addr=%h, required no command",
                         amm_read_o, amm_write_o, amm_address_o);
            end else begin
                e = sb[0];
                if ({amm_read_o, amm_write_o, amm_address_o, amm_burstcount_o, amm_byteenable_o} !==
                    {e.rd, !e.rd, e.addr, e.bc, e.be}) begin
                    bad++;
                    $display("FAIL cmd_beat: got rd=%0b wr=%0b addr=%h bc=%0d be=%h, required rd=%0b wr=%0b addr=%h bc=%0d be=%h",
                             amm_read_o, amm_write_o, amm_address_o, amm_burstcount_o, amm_byteenable_o,
                             e.rd, !e.rd, e.addr, e.bc, e.be);
                end
                if (amm_write_o) begin
                    total++;
                    if (amm_writedata_o !== e.data) begin
                        bad++;
                        $display("FAIL wr_data: got %h, required %h", amm_writedata_o, e.data);
                    end
                end
                if (amm_read_o) rd_cycles++;
                if (!amm_waitrequest_i) begin
                    void'(sb.pop_front());
                    if (amm_write_o) beats++;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic typ, input logic [WAW-1:0] w, input logic [BW-1:0] bc,
                         input logic [BAW-1:0] so, input logic [BAW-1:0] eo, input logic [7:0] pat);
        int guard;
        guard              = 0;
        operation_valid_i  = 1'b1;
        operation_type_i   = typ;
        word_address_i     = w;
        word_burst_count_i = bc;
        start_offset_i     = so;
        end_offset_i       = eo;
        data_pattern_i     = pat;
        while (!cmd_accept_ready_o && guard < 200) begin
            tick();
            guard++;
        end
        if (!cmd_accept_ready_o) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: ready=%0b, required 1", cmd_accept_ready_o);
            operation_valid_i = 1'b0;
            return;
        end
        push_txn(typ, w, bc, so, eo, pat);
        tick();
        operation_valid_i  = 1'b0;
        operation_type_i   = 1'($urandom);
        word_address_i     = WAW'($urandom);
        word_burst_count_i = BW'($urandom);
        start_offset_i     = BAW'($urandom);
        end_offset_i       = BAW'($urandom);
        data_pattern_i     = 8'($urandom);
    endtask

    task automatic wait_idle(input string name);
        int guard;
        guard = 0;
        while ((!cmd_accept_ready_o || sb.size() != 0) && guard < 100) begin
            tick();
            guard++;
        end
        total++;
        if (!cmd_accept_ready_o || sb.size() != 0) begin
            bad++;
            $display("FAIL %s_idle: ready=%0b pending=%0d, required ready=1 pending=0",
                     name, cmd_accept_ready_o, sb.size());
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        tick();
        tick();
        total++;
        if ({cmd_accept_ready_o, busy_o, amm_read_o, amm_write_o} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_ctrl: got ready=%0b busy=%0b rd=%0b wr=%0b, required 1 0 0 0",
                     cmd_accept_ready_o, busy_o, amm_read_o, amm_write_o);
        end
        total++;
        if ({amm_address_o, amm_burstcount_o, amm_byteenable_o, amm_writedata_o} !== '0) begin
            bad++;
            $display("FAIL reset_data: got addr=%h bc=%h be=%h wd=%h, required all zero",
                     amm_address_o, amm_burstcount_o, amm_byteenable_o, amm_writedata_o);
        end
        @(posedge clk);
        #1;
        rst_i  = 1'b1;
        m_lfsr = 32'hFFFF_FFFF;
    endtask

    task automatic test_single_write();
        amm_waitrequest_i = 1'b0;
        beats = 0;
        issue(1'b0, 8'h10, 11'd1, 4'd3, 4'd5, 8'hA5);
        total++;
        if (busy_o !== 1'b1) begin
            bad++;
            $display("FAIL single_busy: got %0b, required 1", busy_o);
        end
        tick();
        total++;
        if (cmd_accept_ready_o !== 1'b1 || beats !== 1) begin
            bad++;
            $display("FAIL single_done: got ready=%0b beats=%0d, required ready=1 beats=1",
                     cmd_accept_ready_o, beats);
        end
    endtask

    task automatic test_stall_write();
        beats = 0;
        amm_waitrequest_i = 1'b0;
        issue(1'b0, 8'h20, 11'd4, 4'd2, 4'd1, 8'h3C);
        tick();
        amm_waitrequest_i = 1'b1;
        repeat (3) tick();
        amm_waitrequest_i = 1'b0;
        wait_idle("stall");
        total++;
        if (beats !== 4) begin
            bad++;
            $display("FAIL stall_beats: got %0d, required 4", beats);
        end
    endtask

    task automatic test_read();
        rd_cycles = 0;
        amm_waitrequest_i = 1'b0;
        issue(1'b1, 8'h40, 11'd8, 4'd0, 4'd0, 8'h00);
        amm_waitrequest_i = 1'b1;
        repeat (3) tick();
        amm_waitrequest_i = 1'b0;
        wait_idle("read");
        total++;
        if (rd_cycles !== 4) begin
            bad++;
            $display("FAIL read_cycles: got %0d, required 4", rd_cycles);
        end
    endtask

    task automatic test_zero_burst();
        beats = 0;
        amm_waitrequest_i = 1'b0;
        issue(1'b0, 8'h7F, 11'd0, 4'd0, 4'd15, 8'h5A);
        wait_idle("zero");
        total++;
        if (beats !== 1) begin
            bad++;
            $display("FAIL zero_beats: got %0d, required 1", beats);
        end
    endtask

    task automatic test_reset_mid();
        amm_waitrequest_i = 1'b0;
        issue(1'b0, 8'h22, 11'd4, 4'd0, 4'd15, 8'hC3);
        tick();
        tick();
        #2;
        rst_i = 1'b0;
        #1;
        total++;
        if ({amm_write_o, cmd_accept_ready_o, amm_burstcount_o} !== {1'b0, 1'b1, 11'd0}) begin
            bad++;
            $display("FAIL async_reset: got wr=%0b ready=%0b bc=%0d, required wr=0 ready=1 bc=0",
                     amm_write_o, cmd_accept_ready_o, amm_burstcount_o);
        end
        sb.delete();
        m_lfsr = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        beats = 0;
        issue(1'b0, 8'h23, 11'd2, 4'd1, 4'd14, 8'h96);
        wait_idle("after_reset");
        total++;
        if (beats !== 2) begin
            bad++;
            $display("FAIL after_reset_beats: got %0d, required 2", beats);
        end
    endtask

    task automatic test_back_to_back();
        beats = 0;
        rd_cycles = 0;
        amm_waitrequest_i = 1'b0;
        issue(1'b0, 8'h30, 11'd3, 4'd4, 4'd7, 8'h11);
`ifndef AMM_CMD_DRIVER_RND_DATA_EN
        start_test_i = 1'b1;
`endif
        issue(1'b1, 8'h31, 11'd2, 4'd0, 4'd0, 8'h00);
        start_test_i = 1'b0;
        issue(1'b0, 8'h32, 11'd1, 4'd0, 4'd0, 8'h22);
        wait_idle("b2b");
        total++;
        if (beats !== 4 || rd_cycles !== 1) begin
            bad++;
            $display("FAIL b2b_counts: got beats=%0d rd=%0d, required beats=4 rd=1", beats, rd_cycles);
        end
    endtask

`ifdef AMM_CMD_DRIVER_RND_DATA_EN
    task automatic test_rnd_data();
        beats = 0;
        amm_waitrequest_i = 1'b0;
        start_test_i = 1'b1;
        tick();
        start_test_i = 1'b0;
        m_lfsr = 32'hFFFF_FFFF;
        issue(1'b0, 8'h50, 11'd3, 4'd0, 4'd15, 8'h00);
        total++;
        if (amm_writedata_o !== {4{32'hFFFF_FFFF}}) begin
            bad++;
            $display("FAIL rnd_first: got %h, required all ones", amm_writedata_o);
        end
        amm_waitrequest_i = 1'b1;
        repeat (2) tick();
        amm_waitrequest_i = 1'b0;
        tick();
        amm_waitrequest_i = 1'b1;
        tick();
        amm_waitrequest_i = 1'b0;
        wait_idle("rnd");
        total++;
        if (beats !== 3) begin
            bad++;
            $display("FAIL rnd_beats: got %0d, required 3", beats);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_write();
        test_stall_write();
        test_read();
        test_zero_burst();
        test_reset_mid();
        test_back_to_back();
`ifdef AMM_CMD_DRIVER_RND_DATA_EN
        test_rnd_data();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
